// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - start/valid handshake bundle for the iterative divider
interface seq_divider_if #(
    parameter int DW = 16,
    parameter int VW = 8
);
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          valid;
    logic          busy;
    logic          div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, valid, busy, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, valid, busy, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative restoring divider, one quotient bit per clock; optional DIV_EARLY_OUT_EN
module seq_divider #(
    parameter int DW = 16,
    parameter int VW = 8
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);
    localparam int CW = $clog2(DW + 1);

    typedef enum logic {IDLE, CALC} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] q_sh_q, q_sh_d;
    logic [VW-1:0] d_reg_q, d_reg_d;
    logic [VW:0]   r_q, r_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] quotient_q, quotient_d;
    logic [VW-1:0] remainder_q, remainder_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          dbz_q, dbz_d;

    logic [VW:0]   rs;
    logic [VW:0]   trial;

    always_comb begin
        state_d     = state_q;
        q_sh_d      = q_sh_q;
        d_reg_d     = d_reg_q;
        r_d         = r_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        valid_d     = 1'b0;
        busy_d      = busy_q;
        dbz_d       = dbz_q;
        rs          = '0;
        trial       = '0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = bus.dividend[VW-1:0];
                        dbz_d       = 1'b1;
                        valid_d     = 1'b1;
                    end
`ifdef DIV_EARLY_OUT_EN
                    // Dividend smaller than divisor: quotient is zero, remainder is the dividend itself.
                    else if (bus.dividend < {{(DW-VW){1'b0}}, bus.divisor}) begin
                        quotient_d  = '0;
                        remainder_d = bus.dividend[VW-1:0];
                        dbz_d       = 1'b0;
                        valid_d     = 1'b1;
                    end
`endif
                    else begin
                        q_sh_d  = bus.dividend;
                        d_reg_d = bus.divisor;
                        r_d     = '0;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = CALC;
                    end
                end
            end

            CALC: begin
                rs    = {r_q[VW-1:0], q_sh_q[DW-1]};
                // Partial remainder stays below the divisor, so a negative trial always sets the top bit.
                trial = rs - {1'b0, d_reg_q};
                if (!trial[VW]) begin
                    r_d    = trial;
                    q_sh_d = {q_sh_q[DW-2:0], 1'b1};
                end else begin
                    r_d    = rs;
                    q_sh_d = {q_sh_q[DW-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DW - 1)) begin
                    quotient_d  = q_sh_d;
                    remainder_d = r_d[VW-1:0];
                    dbz_d       = 1'b0;
                    valid_d     = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            q_sh_q      <= '0;
            d_reg_q     <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_sh_q      <= q_sh_d;
            d_reg_q     <= d_reg_d;
            r_q         <= r_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            dbz_q       <= dbz_d;
        end
    end

    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.valid       = valid_q;
    assign bus.busy        = busy_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench for seq_divider with arithmetic reference model
module tb_seq_divider;
    localparam int DW = 16;
    localparam int VW = 8;

    typedef struct {
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          dbz;
        longint        t;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb[$];
    int   n_vec;
    int   n_err;
    int   busy_total;

    seq_divider_if #(.DW(DW), .VW(VW)) bus ();

    seq_divider #(.DW(DW), .VW(VW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain division; shortcut cases report in the cycle right after the accepting edge.
    function automatic exp_t model(input int a, input int b, input longint t0);
        exp_t e;
        int   edges;
        edges = DW;
        if (b == 0) begin
            e.q   = '1;
            e.r   = a[VW-1:0];
            e.dbz = 1'b1;
            edges = 0;
        end else begin
            e.q   = DW'(a / b);
            e.r   = VW'(a % b);
            e.dbz = 1'b0;
`ifdef DIV_EARLY_OUT_EN
            if (a < b) edges = 0;
`endif
        end
        e.t = t0 + 10 * edges + 5;
        return e;
    endfunction

    task automatic start_op(input int a, input int b);
        longint t0;
        bus.start    = 1'b1;
        bus.dividend = DW'(a);
        bus.divisor  = VW'(b);
        @(posedge clk);
        t0 = $time;
        sb.push_back(model(a, b, t0));
        #1;
        bus.start    = 1'b0;
        bus.dividend = DW'($urandom);
        bus.divisor  = VW'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            chk("result_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.busy) busy_total++;
            if (bus.valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("quotient", bus.quotient, e.q);
                    chk("remainder", bus.remainder, e.r);
                    chk("div_by_zero", bus.div_by_zero, e.dbz);
                    chk("valid_time", $time, e.t);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin : stim
        int b0;
        int a;
        int b;
        int sel;
        n_vec        = 0;
        n_err        = 0;
        busy_total   = 0;
        rst          = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        #3;
        chk("rst_quotient", bus.quotient, 0);
        chk("rst_remainder", bus.remainder, 0);
        chk("rst_valid", bus.valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_dbz", bus.div_by_zero, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        b0 = busy_total;
        start_op(9999, 99);
        wait_idle();
        chk("busy_cycles_full", busy_total - b0, DW);

        // Second start lands in the cycle the first result is valid.
        start_op(1000, 7);
        repeat (DW) @(posedge clk);
        #1;
        start_op(65535, 255);
        wait_idle();

        b0 = busy_total;
        start_op(5, 0);
        wait_idle();
        chk("busy_cycles_dbz", busy_total - b0, 0);
        start_op(8, 2);
        wait_idle();

        start_op(1234, 10);
        repeat (5) @(posedge clk);
        #1;
        bus.start    = 1'b1;
        bus.dividend = 16'd4000;
        bus.divisor  = 8'd40;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_idle();

        start_op(9999, 99);
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_quotient", bus.quotient, 0);
        chk("abort_remainder", bus.remainder, 0);
        chk("abort_valid", bus.valid, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_dbz", bus.div_by_zero, 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        start_op(81, 9);
        wait_idle();

        b0 = busy_total;
        start_op(50, 99);
        wait_idle();
`ifdef DIV_EARLY_OUT_EN
        chk("busy_cycles_early", busy_total - b0, 0);
`else
        chk("busy_cycles_early", busy_total - b0, DW);
`endif

        for (int i = 0; i < 60; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      b = 0;
            else if (sel < 4)  b = int'($urandom_range(1, 15));
            else               b = int'($urandom_range(1, 255));
            sel = int'($urandom_range(0, 4));
            if (sel == 0)      a = int'($urandom_range(0, 65535));
            else if (sel == 1) a = int'($urandom_range(0, 300));
            else               a = int'($urandom_range(0, 9999));
            start_op(a, b);
            wait_idle();
            repeat (int'($urandom_range(0, 2))) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
